reg_port_arbiter: RTL and testbench
===================================

// Module: reg_port_arbiter
// PURPOSE
//  Shares the single read/write port of reg_file between the CPU control unit and a debug host.
//  CPU has priority. A starvation counter guarantees the debug side a slot.
//  Sequences debug single reads/writes and a full register dump (NUM_REGS bytes) over a valid/ready stream.
//  Sits between control unit / debug logic and reg_file; drives all reg_file port inputs.
// PARAMETERS
//  NUM_REGS    12  number of 8-bit entries in reg_file (dump length)
//  WORD_WIDTH   8  entry width; dump bytes are zero-extended to 16 bits
//  MAX_WAIT     4  consecutive CPU-won cycles before a pending debug request is forced through
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  cpu_req     in   1   CPU requests the port this cycle (held until cpu_gnt)
//  cpu_rd_sel  in   5   CPU read select (bit4 = 16-bit pair)
//  cpu_wr_sel  in   5   CPU write select
//  cpu_ext     in   2   CPU inc/dec/inc2 op code (00 = none)
//  cpu_we      in   1   CPU write enable
//  cpu_wdata   in  16   CPU write data
//  cpu_gnt     out  1   CPU owns the port this cycle (combinational)
//  cpu_rdata   out 16   rf_rdata passthrough (valid while cpu_gnt)
//  dbg_req     in   1   debug single access request (held until dbg_gnt)
//  dbg_sel     in   5   debug read/write select
//  dbg_we      in   1   1 = write dbg_wdata, 0 = read
//  dbg_wdata   in  16   debug write data
//  dbg_dump    in   1   start a full dump (sampled in IDLE)
//  dbg_gnt     out  1   debug single access accepted this cycle
//  dbg_rvalid  out  1   dbg_rdata valid (registered)
//  dbg_rdata   out 16   read / dump data (registered)
//  dbg_rready  in   1   host accepts dbg_rdata
//  dbg_busy    out  1   dump or read response in progress
//  rf_rd_sel   out  5   to reg_file rd_sel
//  rf_wr_sel   out  5   to reg_file wr_sel
//  rf_ext      out  2   to reg_file ext
//  rf_we       out  1   to reg_file we
//  rf_wdata    out 16   to reg_file data_in
//  rf_rdata    in  16   from reg_file data_out
// BEHAVIOUR
//  Reset: state=IDLE; wait_cnt=0; idx=0; dbg_rvalid=0; dbg_rdata=0; dbg_busy=0; grants=0; all rf_* outputs 0.
//  Port mux (combinational):
//   - CPU granted: rf_* = cpu_*.
//   - Debug granted: rf_rd_sel=rf_wr_sel=sel; rf_we=dbg_we (0 during dump); rf_wdata=dbg_wdata; rf_ext=00 always.
//   - No owner: rf_we=0, rf_ext=00, sels 0. Nonzero ext must never leak, since reg_file applies ext regardless of we.
//  Debug pending (dbg_pend): IDLE with dbg_req|dbg_dump, or DUMP_RD.
//  Arbitration:
//   - cpu_gnt = cpu_req & ~(dbg_pend & wait_cnt==MAX_WAIT).
//   - Debug wins whenever dbg_pend and cpu_gnt=0.
//   - wait_cnt increments each cycle cpu_gnt & dbg_pend, saturating at MAX_WAIT; clears when debug wins.
//  FSM states: IDLE, RESP, DUMP_RD, DUMP_WAIT.
//   - IDLE, debug wins, dbg_dump=1: enter DUMP_RD with idx=0, dbg_busy=1. dbg_dump beats dbg_req; dbg_gnt stays 0 and the request waits.
//   - IDLE, debug wins, dbg_req write: dbg_gnt=1, reg written at this edge, no response, stay IDLE.
//   - IDLE, debug wins, dbg_req read: dbg_gnt=1, dbg_rdata<=rf_rdata, dbg_rvalid<=1, go RESP.
//   - RESP: hold data until dbg_rvalid&dbg_rready, then dbg_rvalid<=0, go IDLE. One-cycle response latency.
//   - DUMP_RD, debug wins: rf_rd_sel={1'b0,idx}; dbg_rdata<={8'b0,rf_rdata[7:0]}; dbg_rvalid<=1; go DUMP_WAIT.
//   - DUMP_RD, CPU wins: stay in DUMP_RD.
//   - DUMP_WAIT, on handshake: if idx==NUM_REGS-1, idx<=0, dbg_busy<=0, go IDLE; else idx<=idx+1, go DUMP_RD.
//  The CPU may use the port in any cycle debug does not own it, including RESP and DUMP_WAIT.
//  Dump bytes reflect register contents at each byte's read cycle, not a snapshot.
//  dbg_busy is high in RESP, DUMP_RD and DUMP_WAIT.
//  Reset mid-dump aborts immediately; the next dump restarts at idx 0.
// TESTING
//  1. cpu_req=1, wr_sel=5'h02, we=1, wdata=8'hA5, no debug -> cpu_gnt=1 same cycle; rf_we=1; reg D=8'hA5 after edge.
//  2. cpu_req held high, dbg_req read sel=5'h02 -> cpu_gnt=1 for 4 cycles, then 0 for 1 cycle with dbg_gnt=1;
//     next cycle dbg_rvalid=1, dbg_rdata=16'h00A5.
//  3. Regs preloaded 0x10..0x1B, dbg_dump=1, rready=1, CPU idle -> 12 rvalid beats 0x0010..0x001B in order;
//     dbg_busy falls after the 12th beat.
//  4. Dump with dbg_rready toggled 1/0 randomly -> no bytes lost or duplicated; dbg_rdata stable while rvalid&~rready.
//  5. CPU issues ext=01 on wr_sel=5'h10 during DUMP_WAIT -> BC increments once; rf_ext=00 in every debug-owned cycle.
//  6. rst asserted at dump byte 5 -> all outputs return to reset values next cycle; new dump starts at byte 0.

Source files
------------

// File: rtl/reg_port_arbiter.sv
// Arbitrates the single reg_file port between the CPU control unit and a debug host.
// The CPU has priority; a starvation counter forces a pending debug access through.
module reg_port_arbiter #(
    parameter int NUM_REGS   = 12,
    parameter int WORD_WIDTH = 8,
    parameter int MAX_WAIT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [4:0]  cpu_rd_sel,
    input  logic [4:0]  cpu_wr_sel,
    input  logic [1:0]  cpu_ext,
    input  logic        cpu_we,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic [15:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic [4:0]  dbg_sel,
    input  logic        dbg_we,
    input  logic [15:0] dbg_wdata,
    input  logic        dbg_dump,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [15:0] dbg_rdata,
    input  logic        dbg_rready,
    output logic        dbg_busy,
    output logic [4:0]  rf_rd_sel,
    output logic [4:0]  rf_wr_sel,
    output logic [1:0]  rf_ext,
    output logic        rf_we,
    output logic [15:0] rf_wdata,
    input  logic [15:0] rf_rdata
);

    // state     | meaning
    // IDLE      | no debug transaction in flight; single access or dump may start
    // RESP      | single read data held on dbg_rdata until the host accepts it
    // DUMP_RD   | waiting to win the port to read dump byte idx
    // DUMP_WAIT | dump byte idx held on dbg_rdata until the host accepts it
    typedef enum logic [1:0] {IDLE, RESP, DUMP_RD, DUMP_WAIT} state_t;

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [IDX_W-1:0]    idx;
    logic                dbg_pend;
    logic                wait_full;
    logic                dbg_win;
    logic                dump_start;
    logic                last_idx;
    logic [4:0]          dbg_port_sel;

    assign dbg_pend   = ((state == IDLE) && (dbg_req || dbg_dump)) || (state == DUMP_RD);
    assign wait_full  = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign cpu_gnt    = ~rst & cpu_req & ~(dbg_pend & wait_full);
    assign dbg_win    = ~rst & dbg_pend & ~cpu_gnt;
    assign dump_start = dbg_win & (state == IDLE) & dbg_dump;
    // A dump request shadows a simultaneous single access, which keeps waiting.
    assign dbg_gnt    = dbg_win & (state == IDLE) & ~dbg_dump;
    assign last_idx   = (idx == IDX_W'(NUM_REGS - 1));
    assign dbg_port_sel = (state == DUMP_RD) ? 5'(idx) : dbg_sel;
    assign cpu_rdata  = rf_rdata;

    // reg_file applies ext even without we, so ext is forced to zero unless the CPU owns the port.
    always_comb begin
        rf_rd_sel = '0;
        rf_wr_sel = '0;
        rf_ext    = '0;
        rf_we     = 1'b0;
        rf_wdata  = '0;
        if (cpu_gnt) begin
            rf_rd_sel = cpu_rd_sel;
            rf_wr_sel = cpu_wr_sel;
            rf_ext    = cpu_ext;
            rf_we     = cpu_we;
            rf_wdata  = cpu_wdata;
        end else if (dbg_win) begin
            rf_rd_sel = dbg_port_sel;
            rf_wr_sel = dbg_port_sel;
            rf_we     = dbg_gnt & dbg_we;
            rf_wdata  = dbg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            idx        <= '0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
            dbg_busy   <= 1'b0;
        end else begin
            if (dbg_win) begin
                wait_cnt <= '0;
            end else if (cpu_gnt && dbg_pend && !wait_full) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (dump_start) begin
                        idx      <= '0;
                        dbg_busy <= 1'b1;
                        state    <= DUMP_RD;
                    end else if (dbg_gnt && !dbg_we) begin
                        dbg_rdata  <= rf_rdata;
                        dbg_rvalid <= 1'b1;
                        dbg_busy   <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (dbg_rready) begin
                        dbg_rvalid <= 1'b0;
                        dbg_busy   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                DUMP_RD: begin
                    if (dbg_win) begin
                        dbg_rdata  <= {{(16 - WORD_WIDTH){1'b0}}, rf_rdata[WORD_WIDTH-1:0]};
                        dbg_rvalid <= 1'b1;
                        state      <= DUMP_WAIT;
                    end
                end
                DUMP_WAIT: begin
                    if (dbg_rready) begin
                        dbg_rvalid <= 1'b0;
                        if (last_idx) begin
                            idx      <= '0;
                            dbg_busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= DUMP_RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: behavioural reg_file, table-driven CPU writes,
// and a scoreboard queue of expected debug beats popped on each handshake.
module tb_reg_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [4:0]  cpu_rd_sel;
    logic [4:0]  cpu_wr_sel;
    logic [1:0]  cpu_ext;
    logic        cpu_we;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt;
    logic [15:0] cpu_rdata;
    logic        dbg_req;
    logic [4:0]  dbg_sel;
    logic        dbg_we;
    logic [15:0] dbg_wdata;
    logic        dbg_dump;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [15:0] dbg_rdata;
    logic        dbg_rready;
    logic        dbg_busy;
    logic [4:0]  rf_rd_sel;
    logic [4:0]  rf_wr_sel;
    logic [1:0]  rf_ext;
    logic        rf_we;
    logic [15:0] rf_wdata;
    logic [15:0] rf_rdata;

    reg_port_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_rd_sel(cpu_rd_sel), .cpu_wr_sel(cpu_wr_sel),
        .cpu_ext(cpu_ext), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_sel(dbg_sel), .dbg_we(dbg_we), .dbg_wdata(dbg_wdata),
        .dbg_dump(dbg_dump), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata), .dbg_rready(dbg_rready), .dbg_busy(dbg_busy),
        .rf_rd_sel(rf_rd_sel), .rf_wr_sel(rf_wr_sel), .rf_ext(rf_ext),
        .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural reg_file: 12 bytes, bit4 of a select addresses pair {r[2p], r[2p+1]}.
    logic [7:0]  regs [0:11];
    logic [3:0]  rd_hi, rd_lo, wr_hi, wr_lo;
    logic [15:0] wr_pair, ext_pair;

    assign rd_hi = {rf_rd_sel[2:0], 1'b0};
    assign rd_lo = {rf_rd_sel[2:0], 1'b1};
    assign wr_hi = {rf_wr_sel[2:0], 1'b0};
    assign wr_lo = {rf_wr_sel[2:0], 1'b1};
    assign wr_pair  = (wr_lo < 4'd12) ? {regs[wr_hi], regs[wr_lo]} : 16'h0000;
    assign ext_pair = (rf_ext == 2'b01) ? wr_pair + 16'd1 :
                      (rf_ext == 2'b10) ? wr_pair - 16'd1 :
                      (rf_ext == 2'b11) ? wr_pair + 16'd2 : wr_pair;

    always_comb begin
        rf_rdata = 16'h0000;
        if (rf_rd_sel[4]) begin
            if (rd_lo < 4'd12) rf_rdata = {regs[rd_hi], regs[rd_lo]};
        end else if (rf_rd_sel[3:0] < 4'd12) begin
            rf_rdata = {8'h00, regs[rf_rd_sel[3:0]]};
        end
    end

    always @(posedge clk) begin
        if (rf_ext != 2'b00) begin
            if (wr_lo < 4'd12) begin
                regs[wr_hi] <= ext_pair[15:8];
                regs[wr_lo] <= ext_pair[7:0];
            end
        end else if (rf_we) begin
            if (rf_wr_sel[4]) begin
                if (wr_lo < 4'd12) begin
                    regs[wr_hi] <= rf_wdata[15:8];
                    regs[wr_lo] <= rf_wdata[7:0];
                end
            end else if (rf_wr_sel[3:0] < 4'd12) begin
                regs[rf_wr_sel[3:0]] <= rf_wdata[7:0];
            end
        end
    end

    typedef struct {
        logic [4:0]  sel;
        logic [15:0] wdata;
        logic [7:0]  exp_reg;
    } vec_t;

    vec_t        tbl [13];
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          beats  = 0;
    bit          hold_valid = 1'b0;
    logic [15:0] hold_data  = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs once per cycle at the falling edge: port-leak rules, hold stability, scoreboard.
    task automatic mon();
        logic [15:0] e;
        if (rst) begin
            hold_valid = 1'b0;
        end else begin
            if (!cpu_gnt) chk("ext_leak", rf_ext, 0);
            if (!cpu_gnt && !dbg_gnt) chk("we_leak", rf_we, 0);
            if (hold_valid) begin
                chk("hold_valid", dbg_rvalid, 1);
                chk("hold_data", dbg_rdata, hold_data);
            end
            if (dbg_rvalid && dbg_rready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected actual=%0h required=none", dbg_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", dbg_rdata, e);
                end
            end
            hold_valid = dbg_rvalid && !dbg_rready;
            hold_data  = dbg_rdata;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        mon();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [4:0] sel, input logic [15:0] wdata, input logic [7:0] exp_reg);
        cpu_req = 1'b1; cpu_wr_sel = sel; cpu_rd_sel = 5'h00;
        cpu_we = 1'b1; cpu_ext = 2'b00; cpu_wdata = wdata;
        sample();
        chk("wr_gnt", cpu_gnt, 1);
        chk("wr_rf_we", rf_we, 1);
        chk("wr_rf_sel", rf_wr_sel, sel);
        chk("wr_rf_wdata", rf_wdata, wdata);
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        chk("wr_reg", regs[sel[3:0]], exp_reg);
    endtask

    task automatic push_dump(input logic [7:0] byte1);
        for (int i = 0; i < 12; i++)
            exp_q.push_back((i == 1) ? {8'h00, byte1} : 16'h0010 + 16'(i));
    endtask

    task automatic wait_dump_done(input int limit, input bit rnd, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            sample();
            if (!dbg_busy) ok = 1'b1;
            tick();
            if (ok) break;
            if (rnd) dbg_rready = 1'($urandom_range(0, 1));
        end
        chk(name, ok, 1);
    endtask

    task automatic start_dump();
        dbg_dump = 1'b1;
        sample();
        tick();
        dbg_dump = 1'b0;
        sample();
        chk("dump_busy", dbg_busy, 1);
        tick();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rvalid", dbg_rvalid, 0);
        chk("rst_rdata", dbg_rdata, 0);
        chk("rst_busy", dbg_busy, 0);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_rf", {rf_rd_sel, rf_wr_sel, rf_ext, rf_we, rf_wdata}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int b0;
        bit ok;
        for (int i = 0; i < 12; i++) begin
            tbl[i].sel     = 5'(i);
            tbl[i].wdata   = 16'hFF10 + 16'(i);
            tbl[i].exp_reg = 8'h10 + 8'(i);
        end
        tbl[12].sel = 5'h02; tbl[12].wdata = 16'h00A5; tbl[12].exp_reg = 8'hA5;

        rst = 1'b1;
        cpu_req = 0; cpu_rd_sel = 0; cpu_wr_sel = 0; cpu_ext = 0; cpu_we = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_sel = 0; dbg_we = 0; dbg_wdata = 0; dbg_dump = 0; dbg_rready = 1;
        repeat (3) begin sample(); tick(); end
        rst = 1'b0;
        sample();
        chk_reset_outputs();
        tick();

        // Preload 0x10..0x1B (upper wdata byte ignored), then reg 2 = 0xA5.
        for (int i = 0; i < 13; i++) cpu_write(tbl[i].sel, tbl[i].wdata, tbl[i].exp_reg);

        // CPU holds the port; debug read forced through after MAX_WAIT CPU cycles.
        cpu_req = 1'b1; cpu_rd_sel = 5'h03; cpu_we = 1'b0; cpu_ext = 2'b00;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_sel = 5'h02;
        exp_q.push_back(16'h00A5);
        for (int c = 0; c < 5; c++) begin
            sample();
            chk("starve_cpu_gnt", cpu_gnt, (c < 4) ? 1 : 0);
            chk("starve_dbg_gnt", dbg_gnt, (c == 4) ? 1 : 0);
            if (c == 4) chk("starve_rf_sel", rf_rd_sel, 5'h02);
            tick();
        end
        dbg_req = 1'b0; cpu_req = 1'b0;
        sample();
        chk("resp_rvalid", dbg_rvalid, 1);
        chk("resp_rdata", dbg_rdata, 16'h00A5);
        chk("resp_busy", dbg_busy, 1);
        tick();
        sample();
        chk("resp_done_busy", dbg_busy, 0);
        tick();
        cpu_write(5'h02, 16'h0012, 8'h12);

        // Debug single write goes through immediately when the CPU is idle.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_sel = 5'h05; dbg_wdata = 16'h0077;
        sample();
        chk("dwr_gnt", dbg_gnt, 1);
        chk("dwr_rf_we", rf_we, 1);
        tick();
        dbg_req = 1'b0; dbg_we = 1'b0;
        chk("dwr_reg", regs[5], 8'h77);
        sample();
        chk("dwr_no_resp", dbg_rvalid, 0);
        tick();
        cpu_write(5'h05, 16'h0015, 8'h15);

        // Full dump, host always ready.
        b0 = beats;
        push_dump(8'h11);
        start_dump();
        wait_dump_done(100, 1'b0, "dump_done");
        chk("dump_beats", beats - b0, 12);
        chk("dump_queue", exp_q.size(), 0);

        // Dump with random back-pressure.
        b0 = beats;
        push_dump(8'h11);
        start_dump();
        wait_dump_done(600, 1'b1, "bp_dump_done");
        dbg_rready = 1'b1;
        chk("bp_beats", beats - b0, 12);
        chk("bp_queue", exp_q.size(), 0);

        // CPU increments BC while byte 0 waits, then keeps requesting through the dump.
        b0 = beats;
        dbg_rready = 1'b0;
        push_dump(8'h12);
        start_dump();
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            sample();
            if (dbg_rvalid) ok = 1'b1;
            tick();
            if (ok) break;
        end
        chk("dw_reached", ok, 1);
        cpu_req = 1'b1; cpu_wr_sel = 5'h10; cpu_ext = 2'b01; cpu_we = 1'b0; cpu_rd_sel = 5'h13;
        sample();
        chk("dw_cpu_gnt", cpu_gnt, 1);
        chk("dw_rf_ext", rf_ext, 2'b01);
        tick();
        cpu_ext = 2'b00;
        chk("dw_bc", {regs[0], regs[1]}, 16'h1012);
        dbg_rready = 1'b1;
        wait_dump_done(400, 1'b0, "dw_dump_done");
        cpu_req = 1'b0;
        chk("dw_bc_once", {regs[0], regs[1]}, 16'h1012);
        chk("dw_beats", beats - b0, 12);
        chk("dw_queue", exp_q.size(), 0);

        // Reset in the middle of a dump, then a fresh dump from byte 0.
        b0 = beats;
        push_dump(8'h12);
        start_dump();
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            sample();
            if (beats - b0 >= 5) ok = 1'b1;
            tick();
            if (ok) break;
        end
        chk("abort_reached", ok, 1);
        rst = 1'b1;
        sample();
        tick();
        rst = 1'b0;
        exp_q.delete();
        sample();
        chk_reset_outputs();
        tick();
        b0 = beats;
        push_dump(8'h12);
        start_dump();
        wait_dump_done(100, 1'b0, "redump_done");
        chk("redump_beats", beats - b0, 12);
        chk("redump_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
